mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Single-port word memory that answers load/store requests after a fixed,
// parameterised wait, with RISC-V style sub-word lanes and misalignment faults.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_init,
    input  logic [2:0]  mem_read_op,
    input  logic [1:0]  mem_write_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        busy,
    output logic        fault
);

    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [3:0]    wait_cnt;
    logic [3:0]    wait_cnt_next;
    logic          capture;

    logic [AW+1:0] cap_addr;
    logic [31:0]   cap_wdata;
    logic [2:0]    cap_rop;
    logic [1:0]    cap_wop;

    logic [31:0]   rdata_q;
    logic [31:0]   mem [DEPTH_WORDS];

    // Address bits above the array size alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:AW+2];

    // ------------------------------------------------------------------
    // Request decode from the captured fields
    // ------------------------------------------------------------------
    logic is_store;
    logic is_load;
    logic sz_byte;
    logic sz_half;
    logic sz_word;
    logic ld_signed;
    logic misaligned;

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        is_store  = 1'b0;
        is_load   = 1'b0;
        sz_byte   = 1'b0;
        sz_half   = 1'b0;
        sz_word   = 1'b0;
        ld_signed = 1'b0;

        if (cap_wop != 2'b00) begin
            // A store wins over any load op issued alongside it.
            is_store = 1'b1;
            case (cap_wop)
                2'b01:   sz_byte = 1'b1;
                2'b10:   sz_half = 1'b1;
                default: sz_word = 1'b1;
            endcase
        end else begin
            case (cap_rop)
                3'b001: begin is_load = 1'b1; sz_byte = 1'b1; ld_signed = 1'b1; end
                3'b010: begin is_load = 1'b1; sz_half = 1'b1; ld_signed = 1'b1; end
                3'b011: begin is_load = 1'b1; sz_word = 1'b1; end
                3'b101: begin is_load = 1'b1; sz_byte = 1'b1; end
                3'b110: begin is_load = 1'b1; sz_half = 1'b1; end
                default: ;
            endcase
        end
    end

    assign misaligned = (sz_half && cap_addr[0]) ||
                        (sz_word && (cap_addr[1:0] != 2'b00));

    logic [AW-1:0] word_idx;
    logic [31:0]   mem_word;

    assign word_idx = cap_addr[AW+1:2];
    assign mem_word = mem[word_idx];

    // ------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_result;

    always_comb begin
        case (cap_addr[1:0])
            2'd0:    byte_val = mem_word[7:0];
            2'd1:    byte_val = mem_word[15:8];
            2'd2:    byte_val = mem_word[23:16];
            default: byte_val = mem_word[31:24];
        endcase
        half_val = cap_addr[1] ? mem_word[31:16] : mem_word[15:0];

        load_result = '0;
        if (is_load && !misaligned) begin
            if (sz_byte) begin
                load_result = {{24{ld_signed & byte_val[7]}}, byte_val};
            end else if (sz_half) begin
                load_result = {{16{ld_signed & half_val[15]}}, half_val};
            end else begin
                load_result = mem_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Store lane placement and byte enables
    // ------------------------------------------------------------------
    logic [3:0]  store_be;
    logic [31:0] store_data;
    logic        store_en;

    always_comb begin
        store_be   = 4'b0000;
        store_data = cap_wdata;
        if (sz_byte) begin
            store_be   = 4'b0001 << cap_addr[1:0];
            store_data = {4{cap_wdata[7:0]}};
        end else if (sz_half) begin
            store_be   = cap_addr[1] ? 4'b1100 : 4'b0011;
            store_data = {2{cap_wdata[15:0]}};
        end else if (sz_word) begin
            store_be   = 4'b1111;
        end
    end

    assign store_en = (state == ST_RESP) && is_store && !misaligned;

    // NOTE: the storage array has no reset; contents survive reset and the
    // array maps onto plain RAM. Writes are gated by the FSM, which reset
    // forces to IDLE, so an aborted request never commits.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (store_be[b]) begin
                    mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        capture       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_init) begin
                    capture = 1'b1;
                    if (LAT == 4'd0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = LAT;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_rop   <= '0;
            cap_wop   <= '0;
            rdata_q   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (capture) begin
                cap_addr  <= addr[AW+1:0];
                cap_wdata <= wdata;
                cap_rop   <= mem_read_op;
                cap_wop   <= mem_write_op;
            end
            if (state == ST_RESP) begin
                rdata_q <= load_result;
            end
        end
    end

    // rdata shows the fresh result during RESP and the held copy afterwards.
    assign rdata     = (state == ST_RESP) ? load_result : rdata_q;
    assign mem_ready = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign fault     = (state == ST_RESP) && misaligned;

endmodule
